// File: rtl/div_req_ctrl.sv
// div_req_ctrl: request controller in front of the 8-bit signed divider.
// Accepts one divide request at a time and holds the operands on div_a/div_b
// for the whole operation. It pulses div_start once and waits for div_done,
// with a watchdog. The result and a status code go back over a response
// handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid, once raised, stays up with stable payload until that
// edge. req_ready and resp_valid are registered and depend only on state.
//
// Optional feature, macro DIV_ZERO_BYPASS_EN: when it is defined, a zero
// divisor skips the divider and is answered directly with status 01.
//
// TIMEOUT_CYCLES must be >= 16, and 2**CNT_W must be greater than
// TIMEOUT_CYCLES.
module div_req_ctrl #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_quotient,
    output logic [15:0] resp_remainder,
    output logic [1:0]  resp_status,
    output logic        busy,
    output logic        div_start,
    output logic [7:0]  div_a,
    output logic [7:0]  div_b,
    input  logic        div_done,
    input  logic [15:0] div_quotient,
    input  logic [15:0] div_remainder,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_DIVZERO = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_wdog;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_busy;
    logic             r_div_start;
    logic [7:0]       r_div_a;
    logic [7:0]       r_div_b;
    logic [15:0]      r_resp_q;
    logic [15:0]      r_resp_r;
    logic [1:0]       r_resp_status;

    // Controller FSM; every output is a register written on the transition
    // into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wdog        <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_div_start   <= 1'b0;
            r_div_a       <= '0;
            r_div_b       <= '0;
            r_resp_q      <= '0;
            r_resp_r      <= '0;
            r_resp_status <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        // Operands change only here, so they stay stable
                        // until the response handshake completes.
                        r_div_a     <= req_a;
                        r_div_b     <= req_b;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                        if (req_b == 8'd0) begin
                            r_resp_q      <= '0;
                            r_resp_r      <= '0;
                            r_resp_status <= STATUS_DIVZERO;
                            r_resp_valid  <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            r_div_start <= 1'b1;
                            r_state     <= ST_LAUNCH;
                        end
`else
                        r_div_start <= 1'b1;
                        r_state     <= ST_LAUNCH;
`endif
                    end
                end

                ST_LAUNCH: begin
                    // The start pulse lasts exactly this one cycle.
                    r_div_start <= 1'b0;
                    r_wdog      <= '0;
                    r_state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A done in the watchdog's last cycle still counts.
                    if (div_done) begin
                        r_resp_q      <= div_quotient;
                        r_resp_r      <= div_remainder;
                        r_resp_status <= (r_div_b == 8'd0) ? STATUS_DIVZERO : STATUS_OK;
                        r_resp_valid  <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_resp_q      <= '0;
                        r_resp_r      <= '0;
                        r_resp_status <= STATUS_TIMEOUT;
                        r_resp_valid  <= 1'b1;
                        r_state       <= ST_RESP;
                    end else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    if (r_resp_valid && resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign busy           = r_busy;
    assign div_start      = r_div_start;
    assign div_a          = r_div_a;
    assign div_b          = r_div_b;
    assign resp_quotient  = r_resp_q;
    assign resp_remainder = r_resp_r;
    assign resp_status    = r_resp_status;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_div_req_ctrl.sv
// tb_div_req_ctrl: bench for div_req_ctrl with a behavioural divider stub.
// Expected responses are computed from the request operands and the chosen
// divider latency, and queued in exp_q. Define DIV_ZERO_BYPASS_EN for both
// the bench and the DUT to cover the bypass build.
module tb_div_req_ctrl;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_quotient;
  logic [15:0] resp_remainder;
  logic [1:0]  resp_status;
  logic        busy;
  logic        div_start;
  logic [7:0]  div_a;
  logic [7:0]  div_b;
  logic        div_done;
  logic [15:0] div_quotient;
  logic [15:0] div_remainder;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  // divider stub control (written by the main thread only)
  int stub_lat = 0;  // 0 means the divider never answers
  // divider stub state (written by the stub only)
  int stub_cnt = 0;
  int start_count = 0;
  logic [7:0] stub_a, stub_b;

  div_req_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_status(resp_status), .busy(busy),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Divider arithmetic: truncating signed quotient and magnitude remainder.
  // A zero divisor gives 0/0.
  function automatic logic [31:0] div_result(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return 32'd0;
    q = sa / sb;
    r = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
    return {q[15:0], r[15:0]};
  endfunction

  // Reference model: the expected {status, quotient, remainder}, the number of
  // negedges after acceptance at which resp_valid appears, and the start count.
  function automatic logic [33:0] model(input logic [7:0] a, input logic [7:0] b, input int lat,
                                        output int exp_lat, output int exp_starts);
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 8'd0) begin
      exp_lat = 0;
      exp_starts = 0;
      return {2'b01, 32'd0};
    end
`endif
    exp_starts = 1;
    if (lat >= 1 && lat <= TIMEOUT) begin
      exp_lat = lat + 1;
      return {(b == 8'd0) ? 2'b01 : 2'b00, div_result(a, b)};
    end
    exp_lat = TIMEOUT + 1;
    return {2'b10, 32'd0};
  endfunction

  // Behavioural divider: it answers stub_lat cycles after a start pulse and
  // drives random garbage on its result bus whenever done is low.
  always @(negedge clk) begin
    if (reset) begin
      stub_cnt = 0;
      div_done = 1'b0;
    end else begin
      div_done = 1'b0;
      div_quotient = 16'($urandom);
      div_remainder = 16'($urandom);
      if (div_start) begin
        start_count++;
        stub_a = div_a;
        stub_b = div_b;
        stub_cnt = stub_lat;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          div_done = 1'b1;
          {div_quotient, div_remainder} = div_result(stub_a, stub_b);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: runs one request through the controller and checks its response.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int lat, input int hold);
    int n, exp_lat, exp_starts, starts0, w;
    logic [33:0] exp, got;
    bit ok;
    exp = model(a, b, lat, exp_lat, exp_starts);
    exp_q.push_back(exp);
    stub_lat = lat;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    starts0 = start_count;
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 8'($urandom);
    req_b = 8'($urandom);
    n = 0;
    ok = 1'b1;
    while (!resp_valid && n < 60) begin
      if (div_a !== a || div_b !== b || busy !== 1'b1 || req_ready !== 1'b0 ||
          div_start !== (n == 0))
        ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("wait_phase", 64'(ok), 64'd1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("start_pulses", 64'(start_count - starts0), 64'(exp_starts));
    got = {resp_status, resp_quotient, resp_remainder};
    chk("resp", 64'(got), 64'(exp_q.pop_front()));
    // Hold resp_ready low while a competing request is presented.
    req_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || {resp_status, resp_quotient, resp_remainder} !== got ||
          req_ready !== 1'b0 || div_a !== a || div_b !== b || div_start !== 1'b0)
        ok = 1'b0;
    end
    chk("resp_hold", 64'(ok), 64'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b0;
    chk("after_handshake", 64'({resp_valid, req_ready, busy}), 64'(3'b010));
  endtask

  // Reset during WAIT abandons the operation and produces no response.
  task automatic reset_in_wait();
    bit ok;
    stub_lat = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_a = 8'd55;
    req_b = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("in_wait", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wait_outputs", 64'({req_ready, resp_valid, busy, div_start, div_a, div_b, dbg_state}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0}));
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_resp", 64'(ok), 64'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int rl;
    reset = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({req_ready, resp_valid, busy, div_start, div_a, div_b,
                            resp_quotient, resp_remainder, resp_status, dbg_state}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0, 16'd0, 2'd0, 2'd0}));
    reset = 1'b0;

    run_txn(8'd100, 8'd7, 12, 2);
    run_txn(8'h9C, 8'd7, 12, 0);         // -100 / 7
    chk("neg_quotient", 64'(resp_quotient), 64'(16'hFFF2));
    run_txn(8'd77, 8'd0, 12, 1);         // zero divisor
    run_txn(8'd10, 8'd3, 0, 1);          // divider never answers
    run_txn(8'd50, 8'd5, TIMEOUT, 0);    // done in the watchdog's last cycle
    run_txn(8'd50, 8'd5, TIMEOUT + 1, 3);// done arrives late, during RESP
    run_txn(8'd9, 8'd2, TIMEOUT + 4, 0); // done arrives late, during IDLE
    run_txn(8'd127, 8'hFF, 1, 5);        // fastest divider, held response
    reset_in_wait();

    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      rl = $urandom_range(0, 40);
      run_txn(ra, rb, rl, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/div_req_ctrl.md
Name: div_req_ctrl

Overview:
- Upstream request controller for the 8-bit signed non-restoring divider in the ALU.
- Accepts divide requests from the ALU host over a valid/ready handshake, and holds the operands stable on the divider inputs for the whole operation.
- Issues a single-cycle start pulse, waits for the divider's done flag with a watchdog, and captures quotient/remainder.
- Returns the result plus a status code over a second valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 32: max cycles spent in WAIT before declaring timeout; must be >= 16.
- CNT_W, 6: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  host request valid
- req_ready  output  1  controller can accept request
- req_a  input  8  signed dividend
- req_b  input  8  signed divisor
- resp_valid  output  1  response valid
- resp_ready  input  1  host accepts response
- resp_quotient  output  16  signed quotient
- resp_remainder  output  16  remainder as produced by divider
- resp_status  output  2  00 ok, 01 divide-by-zero, 10 timeout, 11 unused
- busy  output  1  high in any state except IDLE
- div_start  output  1  start pulse to divider
- div_a  output  8  dividend to divider (registered)
- div_b  output  8  divisor to divider (registered)
- div_done  input  1  divider done flag
- div_quotient  input  16  divider quotient
- div_remainder  input  16  divider remainder

Behaviour:
- Reset applies to all registers: state=IDLE and every output/register = 0, except req_ready=1. Reset mid-operation abandons the operation; no response is produced. The divider shares the same reset.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_a->div_a, req_b->div_b, go to LAUNCH.
- LAUNCH:
  - div_start=1 for exactly this one cycle; watchdog cleared to 0; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If div_done=1: resp_quotient<=div_quotient, resp_remainder<=div_remainder, resp_status<=(div_b==0)?01:00, go to RESP.
  - Else, if watchdog==TIMEOUT_CYCLES-1: resp_quotient/resp_remainder<=0, resp_status<=10, go to RESP.
  - If div_done and the timeout coincide in the same cycle, div_done wins.
- RESP:
  - resp_valid=1.
  - resp_quotient/resp_remainder/resp_status held stable until resp_valid&&resp_ready.
  - On that handshake: resp_valid<=0, go to IDLE.
- Operand stability: div_a/div_b change only on request acceptance in IDLE. They are stable from LAUNCH through the end of RESP, because the divider samples b in both its INIT and DONE states.
- div_start is 0 in every cycle except LAUNCH. div_done outside WAIT is ignored, including a late done after a timeout.
- Registered outputs: req_ready, resp_valid, busy and div_start are decoded from registered state only, with no combinational path from any input.
- Throughput: one request in flight. Minimum request-to-response latency is 3 cycles plus the divider latency (about 12 cycles with the current divider). A new request is accepted the cycle after the response handshake.
- Arithmetic: none performed on data. Quotient/remainder are passed through bit-exact; status is decoded from div_b only.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: on acceptance with req_b==0, the FSM goes IDLE->RESP directly.
  - div_start is never pulsed; the divider stays idle.
  - resp_quotient=0, resp_remainder=0, resp_status=01; resp_valid is high 1 cycle after acceptance.
- Undefined: a zero divisor follows the normal LAUNCH/WAIT path. The divider returns 0/0, and status 01 is set on capture.

Test Plan:
- req_a=100, req_b=7 -> single div_start pulse; resp_quotient=14, resp_remainder=2, resp_status=00; div_a/div_b held 100/7 through RESP.
- req_a=-100, req_b=7 -> resp_quotient=16'hFFF2 (-14), resp_remainder=2, resp_status=00.
- req_b=0, macro undefined -> one div_start, resp 0/0, status 01. Macro defined -> no div_start, resp_valid 1 cycle after acceptance, 0/0, status 01.
- Stub divider never asserts div_done, TIMEOUT_CYCLES=32 -> resp_valid 33 cycles after the LAUNCH cycle, status 10, results 0. A late div_done in RESP/IDLE is ignored.
- resp_ready held low 5 cycles in RESP -> resp_* stable, req_ready=0, and a second req_valid is not accepted until the cycle after the handshake.
- reset asserted in WAIT -> next cycle state IDLE, req_ready=1, resp_valid=0, busy=0, div_a/div_b=0; no response is emitted.
